// File: rtl/fact_seq_unit_if.sv
// Request/response bundle between a controller and the factorial coprocessor.
// The controller drives start/n_in; the unit returns busy/done/result/overflow.
interface fact_seq_unit_if #(
    parameter int unsigned N_W    = 4,
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic [N_W-1:0]    n_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              overflow;

    modport master (
        output start, n_in,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, n_in,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/fact_seq_unit.sv
// Iterative n! engine: counts n down to 2, multiplying into an accumulator,
// either one multiply per clock or one shift-add partial product per clock.
module fact_seq_unit #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_W      = 4,
    parameter int unsigned MUL_MODE = 0
) (
    input  logic              clock,
    input  logic              reset,
    fact_seq_unit_if.slave    bus
);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [N_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] pp_q, pp_d;
    logic              mcand_lost_q, mcand_lost_d;
    logic              sticky_q, sticky_d;
    logic [BIT_W-1:0]  bit_q, bit_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ovf_q, ovf_d;

    logic [PROD_W-1:0] prod_c;
    logic              prod_ovf_c;
    logic [DATA_W:0]   pp_sum_c;
    logic [DATA_W-1:0] pp_step_c;
    logic              sticky_step_c;
    logic              last_bit_c;
    logic              cnt_le1_c;

    // Arithmetic shared by the control and datapath decisions
    always_comb begin
        prod_c        = PROD_W'(acc_q) * PROD_W'(cnt_q);
        prod_ovf_c    = |prod_c[PROD_W-1:DATA_W];
        pp_sum_c      = (DATA_W+1)'(pp_q) + (DATA_W+1)'(mcand_q);
        pp_step_c     = mplier_q[0] ? pp_sum_c[DATA_W-1:0] : pp_q;
        // Overflow if this add carries out or the added multiplicand already lost bits
        sticky_step_c = sticky_q | (mplier_q[0] & (pp_sum_c[DATA_W] | mcand_lost_q));
        last_bit_c    = (bit_q == BIT_W'(DATA_W - 1));
        cnt_le1_c     = (cnt_q <= N_W'(1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN: begin
                if (cnt_le1_c)          state_d = S_DONE;
                else if (MUL_MODE == 0) state_d = prod_ovf_c ? S_DONE : S_RUN;
                else                    state_d = S_SHIFT;
            end
            S_SHIFT: if (last_bit_c) state_d = sticky_step_c ? S_DONE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        pp_d         = pp_q;
        mcand_lost_d = mcand_lost_q;
        sticky_d     = sticky_q;
        bit_d        = bit_q;
        ovf_d        = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d = bus.n_in;
                    acc_d = DATA_W'(1);
                    ovf_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!cnt_le1_c) begin
                    if (MUL_MODE == 0) begin
                        if (prod_ovf_c) begin
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = prod_c[DATA_W-1:0];
                            cnt_d = cnt_q - N_W'(1);
                        end
                    end else begin
                        mcand_d      = acc_q;
                        mplier_d     = DATA_W'(cnt_q);
                        pp_d         = '0;
                        mcand_lost_d = 1'b0;
                        sticky_d     = 1'b0;
                        bit_d        = '0;
                    end
                end
            end
            S_SHIFT: begin
                pp_d         = pp_step_c;
                sticky_d     = sticky_step_c;
                mcand_d      = mcand_q << 1;
                mcand_lost_d = mcand_lost_q | mcand_q[DATA_W-1];
                mplier_d     = mplier_q >> 1;
                bit_d        = bit_q + BIT_W'(1);
                if (last_bit_c) begin
                    if (sticky_step_c) begin
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = pp_step_c;
                        cnt_d = cnt_q - N_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs are registered off the next state so done and result appear together
    always_comb begin
        busy_d   = (state_d == S_RUN) || (state_d == S_SHIFT);
        done_d   = (state_d == S_DONE);
        result_d = result_q;
        if (done_d) result_d = ovf_d ? '1 : acc_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            pp_q         <= '0;
            mcand_lost_q <= 1'b0;
            sticky_q     <= 1'b0;
            bit_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            pp_q         <= pp_d;
            mcand_lost_q <= mcand_lost_d;
            sticky_q     <= sticky_d;
            bit_q        <= bit_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
endmodule
